// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the PPU row sequencer
package ppu_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_TILE   = 2'd1,
        SEQ_SPRITE = 2'd2
    } seq_state_t;

    localparam int PATRAM_AW = 12;

    localparam int LAYER_BG = 0;
    localparam int LAYER_FG = 1;
    localparam int LAYER_SP = 2;

endpackage

// File: rtl/ppu_seq_watchdog.sv
// rtl/ppu_seq_watchdog.sv - cycle counter that flags when a render phase overstays its budget
module ppu_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = run && (count_q == LAST);

    // Holds at the terminal value so the pulse cannot repeat before the owner restarts it
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ppu_row_sequencer.sv
// rtl/ppu_row_sequencer.sv - per-row scheduler: tile engines, then sprite engine, with overrun/timeout status
module ppu_row_sequencer #(
    parameter int TIMEOUT_CYCLES = 1600,
    parameter int OVR_CNT_W      = 8,
    parameter int PATRAM_AW      = ppu_pkg::PATRAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rowram_swap,
    input  logic [2:0]           enable,
    input  logic                 bgte_done,
    input  logic                 fgte_done,
    input  logic                 spre_done,
    input  logic [PATRAM_AW-1:0] bgte_patram_addr,
    input  logic [PATRAM_AW-1:0] spre_patram_addr,
    input  logic                 status_clr,
    output logic                 te_prep,
    output logic                 spre_prep,
    output logic [2:0]           en_snap,
    output logic [PATRAM_AW-1:0] patram_addr_a,
    output logic                 row_busy,
    output logic                 row_done,
    output logic                 overrun,
    output logic                 timeout,
    output logic [OVR_CNT_W-1:0] ovr_count
);

    import ppu_pkg::*;

    seq_state_t           state_q, state_d;
    logic                 te_prep_q, te_prep_d;
    logic                 spre_prep_q, spre_prep_d;
    logic                 row_done_q, row_done_d;
    logic                 row_busy_q, row_busy_d;
    logic [2:0]           en_snap_q, en_snap_d;
    logic                 patram_sel_q, patram_sel_d;
    logic                 bg_f_q, bg_f_d;
    logic                 fg_f_q, fg_f_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [OVR_CNT_W-1:0] ovr_count_q, ovr_count_d;
    logic [OVR_CNT_W-1:0] ovr_base;

    logic busy;
    logic bg_ok;
    logic fg_ok;
    logic wd_clr;
    logic wd_expired;
    logic timeout_evt;
    logic ovr_evt;

    assign busy  = (state_q != SEQ_IDLE);
    assign bg_ok = bg_f_q || bgte_done || !en_snap_q[LAYER_BG];
    assign fg_ok = fg_f_q || fgte_done || !en_snap_q[LAYER_FG];

    ppu_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .run    (busy),
        .expired(wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        te_prep_d    = 1'b0;
        spre_prep_d  = 1'b0;
        row_done_d   = 1'b0;
        en_snap_d    = en_snap_q;
        patram_sel_d = patram_sel_q;
        bg_f_d       = bg_f_q;
        fg_f_d       = fg_f_q;
        wd_clr       = 1'b0;
        timeout_evt  = 1'b0;
        ovr_evt      = 1'b0;

        // A swap restarts the row from any state; done pulses in this cycle belong to the old row
        if (rowram_swap) begin
            state_d      = SEQ_TILE;
            te_prep_d    = 1'b1;
            en_snap_d    = enable;
            patram_sel_d = 1'b0;
            bg_f_d       = 1'b0;
            fg_f_d       = 1'b0;
            wd_clr       = 1'b1;
            ovr_evt      = busy;
        end else begin
            case (state_q)
                SEQ_TILE: begin
                    bg_f_d = bg_f_q || bgte_done;
                    fg_f_d = fg_f_q || fgte_done;
                    if (bg_ok && fg_ok) begin
                        state_d      = SEQ_SPRITE;
                        spre_prep_d  = 1'b1;
                        patram_sel_d = 1'b1;
                        wd_clr       = 1'b1;
                    end else if (wd_expired) begin
                        state_d     = SEQ_IDLE;
                        timeout_evt = 1'b1;
                    end
                end
                SEQ_SPRITE: begin
                    if (spre_done || !en_snap_q[LAYER_SP]) begin
                        state_d    = SEQ_IDLE;
                        row_done_d = 1'b1;
                    end else if (wd_expired) begin
                        state_d     = SEQ_IDLE;
                        timeout_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                end
            endcase
        end

        row_busy_d = (state_d != SEQ_IDLE);

        // Clear first, then let a same-cycle event re-assert the status
        ovr_base    = status_clr ? '0 : ovr_count_q;
        ovr_count_d = ovr_base;
        if (ovr_evt && (ovr_base != {OVR_CNT_W{1'b1}})) begin
            ovr_count_d = ovr_base + 1'b1;
        end
        overrun_d = (overrun_q && !status_clr) || ovr_evt;
        timeout_d = (timeout_q && !status_clr) || timeout_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            te_prep_q    <= 1'b0;
            spre_prep_q  <= 1'b0;
            row_done_q   <= 1'b0;
            row_busy_q   <= 1'b0;
            en_snap_q    <= 3'b000;
            patram_sel_q <= 1'b0;
            bg_f_q       <= 1'b0;
            fg_f_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            ovr_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            te_prep_q    <= te_prep_d;
            spre_prep_q  <= spre_prep_d;
            row_done_q   <= row_done_d;
            row_busy_q   <= row_busy_d;
            en_snap_q    <= en_snap_d;
            patram_sel_q <= patram_sel_d;
            bg_f_q       <= bg_f_d;
            fg_f_q       <= fg_f_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            ovr_count_q  <= ovr_count_d;
        end
    end

    assign patram_addr_a = patram_sel_q ? spre_patram_addr : bgte_patram_addr;
    assign te_prep       = te_prep_q;
    assign spre_prep     = spre_prep_q;
    assign row_done      = row_done_q;
    assign row_busy      = row_busy_q;
    assign en_snap       = en_snap_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
    assign ovr_count     = ovr_count_q;

endmodule

// File: tb/tb_ppu_row_sequencer.sv
// tb/tb_ppu_row_sequencer.sv - directed self-checking bench for ppu_row_sequencer
module tb_ppu_row_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rowram_swap = 1'b0;
    logic [2:0]  enable = 3'b111;
    logic        bgte_done = 1'b0;
    logic        fgte_done = 1'b0;
    logic        spre_done = 1'b0;
    logic [11:0] bgte_addr = 12'h123;
    logic [11:0] spre_addr = 12'habc;
    logic        status_clr = 1'b0;

    logic        te_prep_a, spre_prep_a, row_busy_a, row_done_a, overrun_a, timeout_a;
    logic [2:0]  en_snap_a;
    logic [11:0] patram_a;
    logic [7:0]  ovr_count_a;

    logic        te_prep_b, spre_prep_b, row_busy_b, row_done_b, overrun_b, timeout_b;
    logic [2:0]  en_snap_b;
    logic [11:0] patram_b;
    logic [7:0]  ovr_count_b;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ppu_row_sequencer #(
        .TIMEOUT_CYCLES(1600),
        .OVR_CNT_W(8),
        .PATRAM_AW(12)
    ) dut_a (
        .clk(clk), .rst(rst), .rowram_swap(rowram_swap), .enable(enable),
        .bgte_done(bgte_done), .fgte_done(fgte_done), .spre_done(spre_done),
        .bgte_patram_addr(bgte_addr), .spre_patram_addr(spre_addr), .status_clr(status_clr),
        .te_prep(te_prep_a), .spre_prep(spre_prep_a), .en_snap(en_snap_a),
        .patram_addr_a(patram_a), .row_busy(row_busy_a), .row_done(row_done_a),
        .overrun(overrun_a), .timeout(timeout_a), .ovr_count(ovr_count_a)
    );

    ppu_row_sequencer #(
        .TIMEOUT_CYCLES(16),
        .OVR_CNT_W(8),
        .PATRAM_AW(12)
    ) dut_b (
        .clk(clk), .rst(rst), .rowram_swap(rowram_swap), .enable(enable),
        .bgte_done(bgte_done), .fgte_done(fgte_done), .spre_done(spre_done),
        .bgte_patram_addr(bgte_addr), .spre_patram_addr(spre_addr), .status_clr(status_clr),
        .te_prep(te_prep_b), .spre_prep(spre_prep_b), .en_snap(en_snap_b),
        .patram_addr_a(patram_b), .row_busy(row_busy_b), .row_done(row_done_b),
        .overrun(overrun_b), .timeout(timeout_b), .ovr_count(ovr_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            rowram_swap = 1'b0;
            bgte_done   = 1'b0;
            fgte_done   = 1'b0;
            spre_done   = 1'b0;
            status_clr  = 1'b0;
        end
    endtask

    task automatic goto_cyc(input int t);
        if (t > cyc) step(t - cyc);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_te_prep", te_prep_a, 1'b0);
        chk("rst_spre_prep", spre_prep_a, 1'b0);
        chk("rst_row_busy", row_busy_a, 1'b0);
        chk("rst_row_done", row_done_a, 1'b0);
        chk("rst_overrun", overrun_a, 1'b0);
        chk("rst_timeout", timeout_a, 1'b0);
        chk("rst_en_snap", en_snap_a, 3'b000);
        chk("rst_ovr_count", ovr_count_a, 8'd0);
        chk("rst_patram", patram_a, 12'h123);

        // Test 1: nominal row
        enable = 3'b111;
        goto_cyc(10); rowram_swap = 1'b1; step(1);
        chk("t1_te_prep11", te_prep_a, 1'b1);
        chk("t1_busy11", row_busy_a, 1'b1);
        chk("t1_en_snap", en_snap_a, 3'b111);
        chk("t1_patram_bg", patram_a, 12'h123);
        step(1);
        chk("t1_te_prep12", te_prep_a, 1'b0);
        goto_cyc(40); bgte_done = 1'b1; step(1);
        chk("t1_spre_prep41", spre_prep_a, 1'b0);
        goto_cyc(55); fgte_done = 1'b1; step(1);
        chk("t1_spre_prep56", spre_prep_a, 1'b1);
        chk("t1_patram_sp56", patram_a, 12'habc);
        step(1);
        chk("t1_spre_prep57", spre_prep_a, 1'b0);
        goto_cyc(90);
        chk("t1_busy90", row_busy_a, 1'b1);
        chk("t1_done90", row_done_a, 1'b0);
        spre_done = 1'b1; step(1);
        chk("t1_done91", row_done_a, 1'b1);
        chk("t1_busy91", row_busy_a, 1'b0);
        chk("t1_patram_sp91", patram_a, 12'habc);
        chk("t1_overrun", overrun_a, 1'b0);
        step(1);
        chk("t1_done92", row_done_a, 1'b0);

        // Test 2: FG disabled, then all layers disabled
        do_reset();
        goto_cyc(10); enable = 3'b101; rowram_swap = 1'b1; step(1);
        chk("t2_en_snap", en_snap_a, 3'b101);
        goto_cyc(30); bgte_done = 1'b1; step(1);
        chk("t2_spre_prep31", spre_prep_a, 1'b1);
        goto_cyc(35); spre_done = 1'b1; step(1);
        chk("t2_done36", row_done_a, 1'b1);
        goto_cyc(38); spre_done = 1'b1; step(1);
        chk("t2_idle_done39", row_done_a, 1'b0);
        goto_cyc(40); enable = 3'b000; rowram_swap = 1'b1; step(1);
        chk("t2_te_prep41", te_prep_a, 1'b1);
        chk("t2_overrun41", overrun_a, 1'b0);
        step(1);
        chk("t2_spre_prep42", spre_prep_a, 1'b1);
        step(1);
        chk("t2_done43", row_done_a, 1'b1);
        chk("t2_busy43", row_busy_a, 1'b0);

        // Test 3: overruns and saturation
        do_reset();
        enable = 3'b111;
        goto_cyc(10); rowram_swap = 1'b1; step(1);
        goto_cyc(50); rowram_swap = 1'b1; step(1);
        chk("t3_te_prep51", te_prep_a, 1'b1);
        chk("t3_overrun51", overrun_a, 1'b1);
        chk("t3_ovr_count51", ovr_count_a, 8'd1);
        chk("t3_done51", row_done_a, 1'b0);
        for (int i = 0; i < 299; i++) begin
            rowram_swap = 1'b1;
            step(1);
        end
        chk("t3_ovr_sat", ovr_count_a, 8'd255);
        rowram_swap = 1'b1; status_clr = 1'b1; step(1);
        chk("t3_clr_evt_cnt", ovr_count_a, 8'd1);
        chk("t3_clr_evt_ovr", overrun_a, 1'b1);
        status_clr = 1'b1; step(1);
        chk("t3_clr_cnt", ovr_count_a, 8'd0);
        chk("t3_clr_ovr", overrun_a, 1'b0);

        // Test 4: watchdog on the TIMEOUT_CYCLES=16 instance
        do_reset();
        goto_cyc(10); rowram_swap = 1'b1; step(1);
        goto_cyc(26);
        chk("t4_busy26", row_busy_b, 1'b1);
        chk("t4_timeout26", timeout_b, 1'b0);
        step(1);
        chk("t4_busy27", row_busy_b, 1'b0);
        chk("t4_timeout27", timeout_b, 1'b1);
        chk("t4_done27", row_done_b, 1'b0);
        chk("t4_patram27", patram_b, 12'h123);
        goto_cyc(30); status_clr = 1'b1; step(1);
        chk("t4_timeout31", timeout_b, 1'b0);

        // Test 5: done pulses coincident with swap are discarded
        do_reset();
        goto_cyc(10); rowram_swap = 1'b1; bgte_done = 1'b1; fgte_done = 1'b1; step(1);
        chk("t5_te_prep11", te_prep_a, 1'b1);
        step(1);
        chk("t5_spre_prep12", spre_prep_a, 1'b0);
        goto_cyc(20);
        chk("t5_busy20", row_busy_a, 1'b1);
        chk("t5_patram20", patram_a, 12'h123);
        bgte_done = 1'b1; step(1);
        chk("t5_spre_prep21", spre_prep_a, 1'b0);
        goto_cyc(25); fgte_done = 1'b1; step(1);
        chk("t5_spre_prep26", spre_prep_a, 1'b1);

        // Test 6: reset during SPRITE
        do_reset();
        goto_cyc(10); rowram_swap = 1'b1; step(1);
        goto_cyc(15); bgte_done = 1'b1; fgte_done = 1'b1; step(1);
        chk("t6_spre_prep16", spre_prep_a, 1'b1);
        goto_cyc(60);
        chk("t6_busy60", row_busy_a, 1'b1);
        chk("t6_patram60", patram_a, 12'habc);
        rst = 1'b1; bgte_addr = 12'h456; step(1);
        chk("t6_busy61", row_busy_a, 1'b0);
        chk("t6_en_snap61", en_snap_a, 3'b000);
        chk("t6_spre_prep61", spre_prep_a, 1'b0);
        chk("t6_done61", row_done_a, 1'b0);
        chk("t6_patram61", patram_a, 12'h456);
        rst = 1'b0;
        step(2);
        chk("t6_te_prep63", te_prep_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
